// File: rtl/mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared definitions for the EX/MEM-to-data-memory access sequencer:
//   - state_t     : sequencer state, fixed 2-bit encoding
//   - ADDR_W_DEF  : default address width
//   - DATA_W_DEF  : default data width
// -----------------------------------------------------------------------------
package mem_ctrl_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    // The encoding is fixed so that state values are stable across both builds
    // (ST_WAIT_W is only reachable when posted writes are enabled).
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_DONE   = 2'd2,
        ST_WAIT_W = 2'd3
    } state_t;

endpackage

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
// Turns the single-cycle MemRead/MemWrite controls held in EX/MEM into exactly
// one req/ack transaction on a multi-cycle data memory, stalling the upstream
// pipeline while the transaction is outstanding and registering load data for
// MEM/WB.
//
// Build option:
//   MEM_CTRL_POSTED_WR_EN - when defined, stores are posted: the store leaves
//                           EX/MEM immediately and the address/data output
//                           registers act as a one-entry write buffer until the
//                           memory acknowledges it (state ST_WAIT_W).
//
// Ports:
//   clk_i        in   clock, all state on rising edge
//   rst_n_i      in   asynchronous active-low reset
//   MemRead_i    in   load in EX/MEM
//   MemWrite_i   in   store in EX/MEM (wins when both are set)
//   addr_i       in   EX/MEM ALU result (access address)
//   wdata_i      in   EX/MEM store data
//   stall_o      out  hold PC, IF/ID, ID/EX, EX/MEM this cycle (combinational)
//   rdata_o      out  registered load data to MEM/WB
//   mem_req_o    out  level request, held until mem_ack_i
//   mem_we_o     out  1 = write, 0 = read
//   mem_addr_o   out  transaction address
//   mem_wdata_o  out  transaction write data
//   mem_ack_i    in   one-cycle completion pulse
//   mem_rdata_i  in   read data, valid with mem_ack_i
// -----------------------------------------------------------------------------
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              stall_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    state_t            state_r;
    state_t            next_state_s;

    logic              access_s;
    logic              we_s;
    logic              stall_s;
    logic              launch_s;
    logic              ack_done_s;
    logic              rd_capture_s;

    logic              mem_req_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic [DATA_W-1:0] rdata_r;

    assign access_s = MemRead_i | MemWrite_i;
    assign we_s     = MemWrite_i;

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (access_s) begin
`ifdef MEM_CTRL_POSTED_WR_EN
                    next_state_s = we_s ? ST_WAIT_W : ST_WAIT;
`else
                    next_state_s = ST_WAIT;
`endif
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (mem_ack_i) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            // EX/MEM still shows the completed instruction here, so inputs are ignored.
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
`ifdef MEM_CTRL_POSTED_WR_EN
            // Posted write drains straight back to IDLE; a waiting access is issued from there.
            ST_WAIT_W: begin
                if (mem_ack_i) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_WAIT_W;
                end
            end
`endif
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Output and control-strobe decode.
    always_comb begin
        stall_s      = 1'b0;
        launch_s     = 1'b0;
        ack_done_s   = 1'b0;
        rd_capture_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (access_s) begin
                    launch_s = 1'b1;
`ifdef MEM_CTRL_POSTED_WR_EN
                    stall_s  = ~we_s;
`else
                    stall_s  = 1'b1;
`endif
                end else begin
                    stall_s  = 1'b0;
                end
            end
            ST_WAIT: begin
                stall_s = 1'b1;
                if (mem_ack_i) begin
                    ack_done_s   = 1'b1;
                    rd_capture_s = ~mem_we_r;
                end else begin
                    ack_done_s   = 1'b0;
                    rd_capture_s = 1'b0;
                end
            end
            ST_DONE: begin
                stall_s = 1'b0;
            end
`ifdef MEM_CTRL_POSTED_WR_EN
            // Any new access waits behind the buffered write, including in the ack cycle.
            ST_WAIT_W: begin
                stall_s = access_s;
                if (mem_ack_i) begin
                    ack_done_s = 1'b1;
                end else begin
                    ack_done_s = 1'b0;
                end
            end
`endif
            default: begin
                stall_s = 1'b0;
            end
        endcase
    end

    // Transaction registers: request level plus address/data/direction (also the write buffer).
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
        end else if (launch_s) begin
            mem_req_r   <= 1'b1;
            mem_we_r    <= we_s;
            mem_addr_r  <= addr_i;
            mem_wdata_r <= wdata_i;
        end else if (ack_done_s) begin
            mem_req_r   <= 1'b0;
        end
    end

    // Load data register: updated only on read acknowledges.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rdata_r <= {DATA_W{1'b0}};
        end else if (rd_capture_s) begin
            rdata_r <= mem_rdata_i;
        end
    end

    assign stall_o     = stall_s;
    assign rdata_o     = rdata_r;
    assign mem_req_o   = mem_req_r;
    assign mem_we_o    = mem_we_r;
    assign mem_addr_o  = mem_addr_r;
    assign mem_wdata_o = mem_wdata_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
// Directed bench for mem_access_ctrl. The bench plays the data memory itself,
// driving mem_ack_i/mem_rdata_i on chosen cycles, and checks every output
// against hand-computed values. Inputs change and outputs are sampled a few ns
// after the rising edge.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        stall_o;
    logic [31:0] rdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    int n_cmp = 0;
    int n_err = 0;

    mem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .MemRead_i   (MemRead_i),
        .MemWrite_i  (MemWrite_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .stall_o     (stall_o),
        .rdata_o     (rdata_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to 2 ns after the next rising edge.
    task automatic cyc();
        @(posedge clk_i);
        #2;
    endtask

    // One complete access starting in IDLE: ack in the n_wait-th WAIT cycle.
    // Ends in the IDLE cycle following DONE with the access inputs still applied.
    task automatic run_access(input string tag, input logic rd, input logic wr,
                              input logic [31:0] a, input logic [31:0] wd,
                              input int n_wait, input logic [31:0] ack_data,
                              input logic exp_we, input logic [31:0] exp_rdata);
        int stall_cnt;
        stall_cnt  = 0;
        MemRead_i  = rd;
        MemWrite_i = wr;
        addr_i     = a;
        wdata_i    = wd;
        #1;
        check_eq({tag, "_idle_req"}, {31'd0, mem_req_o}, 32'd0);
        stall_cnt += int'(stall_o);
        cyc();
        for (int i = 0; i < n_wait; i++) begin
            check_eq({tag, "_wait_req"},  {31'd0, mem_req_o}, 32'd1);
            check_eq({tag, "_wait_we"},   {31'd0, mem_we_o},  {31'd0, exp_we});
            check_eq({tag, "_wait_addr"}, mem_addr_o, a);
            if (exp_we) begin
                check_eq({tag, "_wait_wdata"}, mem_wdata_o, wd);
            end
            stall_cnt += int'(stall_o);
            if (i == n_wait - 1) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = ack_data;
            end
            cyc();
            mem_ack_i   = 1'b0;
            mem_rdata_i = 32'h0000_0000;
        end
        #1;
        check_eq({tag, "_done_stall"}, {31'd0, stall_o},   32'd0);
        check_eq({tag, "_done_req"},   {31'd0, mem_req_o}, 32'd0);
        check_eq({tag, "_done_rdata"}, rdata_o, exp_rdata);
        check_eq({tag, "_stall_cycles"}, stall_cnt, n_wait + 1);
        cyc();
    endtask

    initial begin
        rst_n_i     = 1'b0;
        MemRead_i   = 1'b0;
        MemWrite_i  = 1'b0;
        addr_i      = 32'h0000_0000;
        wdata_i     = 32'h0000_0000;
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'h0000_0000;
        #1;
        check_eq("rst_req",   {31'd0, mem_req_o}, 32'd0);
        check_eq("rst_we",    {31'd0, mem_we_o},  32'd0);
        check_eq("rst_addr",  mem_addr_o,  32'd0);
        check_eq("rst_wdata", mem_wdata_o, 32'd0);
        check_eq("rst_rdata", rdata_o,     32'd0);
        check_eq("rst_stall", {31'd0, stall_o},   32'd0);
        cyc();
        cyc();
        rst_n_i = 1'b1;
        cyc();

        // Read 0x40, ack in first WAIT cycle.
        run_access("rd40", 1'b1, 1'b0, 32'h40, 32'h0, 1, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF);
        MemRead_i = 1'b0;
        #1;
        check_eq("rd40_after_stall", {31'd0, stall_o}, 32'd0);
        cyc();

        // Reset during WAIT: request drops at once, load data cleared, late ack ignored.
        MemRead_i = 1'b1;
        addr_i    = 32'h10;
        #1;
        check_eq("rstw_idle_stall", {31'd0, stall_o},   32'd1);
        check_eq("rstw_idle_req",   {31'd0, mem_req_o}, 32'd0);
        cyc();
        check_eq("rstw_wait_req",   {31'd0, mem_req_o}, 32'd1);
        check_eq("rstw_wait_addr",  mem_addr_o, 32'h10);
        rst_n_i   = 1'b0;
        MemRead_i = 1'b0;
        #1;
        check_eq("rstw_req_async",  {31'd0, mem_req_o}, 32'd0);
        check_eq("rstw_stall",      {31'd0, stall_o},   32'd0);
        check_eq("rstw_rdata",      rdata_o, 32'd0);
        cyc();
        rst_n_i     = 1'b1;
        cyc();
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h0000_0BAD;
        cyc();
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'h0000_0000;
        #1;
        check_eq("rstw_late_rdata", rdata_o, 32'd0);
        check_eq("rstw_late_req",   {31'd0, mem_req_o}, 32'd0);
        check_eq("rstw_late_stall", {31'd0, stall_o},   32'd0);
        cyc();

        // Write 0x44, ack in third WAIT cycle; rdata untouched.
        run_access("wr44", 1'b0, 1'b1, 32'h44, 32'h1234_5678, 3, 32'hFFFF_FFFF, 1'b1, 32'd0);
        MemWrite_i = 1'b0;
        cyc();

        // Load data for the following stray-ack check.
        run_access("rd48", 1'b1, 1'b0, 32'h48, 32'h0, 1, 32'h0000_5A5A, 1'b0, 32'h0000_5A5A);
        MemRead_i = 1'b0;
        cyc();

        // Both controls set: treated as a write.
        run_access("both8", 1'b1, 1'b1, 32'h8, 32'hAAAA_5555, 1, 32'h1111_1111, 1'b1, 32'h0000_5A5A);
        MemRead_i  = 1'b0;
        MemWrite_i = 1'b0;
        cyc();

        // Back-to-back loads 0x0 then 0x4 with immediate acks.
        run_access("b2b0", 1'b1, 1'b0, 32'h0, 32'h0, 1, 32'h0000_00A0, 1'b0, 32'h0000_00A0);
        run_access("b2b4", 1'b1, 1'b0, 32'h4, 32'h0, 1, 32'h0000_00B4, 1'b0, 32'h0000_00B4);
        MemRead_i = 1'b0;
        #1;
        check_eq("b2b_end_req", {31'd0, mem_req_o}, 32'd0);
        cyc();

        // Ack outside a transaction is ignored.
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h0000_0055;
        cyc();
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'h0000_0000;
        #1;
        check_eq("stray_rdata", rdata_o, 32'h0000_00B4);
        check_eq("stray_req",   {31'd0, mem_req_o}, 32'd0);
        check_eq("stray_stall", {31'd0, stall_o},   32'd0);
        cyc();

`ifdef MEM_CTRL_POSTED_WR_EN
        // Posted store 0x20, load 0x20 behind it, store ack two cycles later.
        MemWrite_i = 1'b1;
        addr_i     = 32'h20;
        wdata_i    = 32'h0000_CAFE;
        #1;
        check_eq("pw_store_stall", {31'd0, stall_o}, 32'd0);
        cyc();
        MemWrite_i = 1'b0;
        MemRead_i  = 1'b1;
        #1;
        check_eq("pw_ww_req",   {31'd0, mem_req_o}, 32'd1);
        check_eq("pw_ww_we",    {31'd0, mem_we_o},  32'd1);
        check_eq("pw_ld_stall1", {31'd0, stall_o},  32'd1);
        cyc();
        mem_ack_i = 1'b1;
        #1;
        check_eq("pw_ld_stall2", {31'd0, stall_o},  32'd1);
        cyc();
        mem_ack_i = 1'b0;
        #1;
        check_eq("pw_ld_idle_stall", {31'd0, stall_o},   32'd1);
        check_eq("pw_ld_idle_req",   {31'd0, mem_req_o}, 32'd0);
        cyc();
        check_eq("pw_ld_req",  {31'd0, mem_req_o}, 32'd1);
        check_eq("pw_ld_we",   {31'd0, mem_we_o},  32'd0);
        check_eq("pw_ld_addr", mem_addr_o, 32'h20);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h0000_0077;
        cyc();
        mem_ack_i   = 1'b0;
        #1;
        check_eq("pw_ld_rdata", rdata_o, 32'h0000_0077);
        check_eq("pw_ld_done_stall", {31'd0, stall_o}, 32'd0);
        cyc();
        MemRead_i = 1'b0;
        cyc();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
